// File: rtl/booth_radix2_divider.sv
// Sequential signed divider: 2*W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Unsigned restoring core with sign pre-processing and post-correction; start/ready handshake.
module booth_radix2_divider #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int unsigned PW = DIVISOR_W + 1;
  localparam int unsigned CW = $clog2(DIVIDEND_W + 1);
  localparam logic [DIVIDEND_W-1:0] QLIM = DIVIDEND_W'(1) << (DIVISOR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_CORRECT} state_t;

  state_t                r_state, w_next;
  logic                  r_sign_q, r_sign_r, r_dz;
  logic [DIVIDEND_W-1:0] r_dq;
  logic [DIVISOR_W-1:0]  r_dvs, r_dvd_lo;
  logic [PW-1:0]         r_rem;
  logic [CW-1:0]         r_cnt;

  logic [DIVIDEND_W-1:0] w_dvd_mag;
  logic [DIVISOR_W-1:0]  w_dvs_mag, w_qlo, w_rm;
  logic [PW-1:0]         w_sh;
  logic [PW:0]           w_diff;
  logic                  w_ge, w_ovf, w_dz_in;

  assign w_dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[DIVISOR_W-1] ? -divisor : divisor;
  assign w_dz_in   = (divisor == '0);

  // Bit shifted out of the partial remainder guarantees the trial subtraction succeeds.
  assign w_sh   = {r_rem[PW-2:0], r_dq[DIVIDEND_W-1]};
  assign w_diff = {1'b0, w_sh} - {2'b00, r_dvs};
  assign w_ge   = r_rem[PW-1] | ~w_diff[PW];

  assign w_qlo = r_dq[DIVISOR_W-1:0];
  assign w_rm  = r_rem[DIVISOR_W-1:0];
  assign w_ovf = r_sign_q ? (r_dq > QLIM) : (r_dq > (QLIM - DIVIDEND_W'(1)));

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = w_dz_in ? S_CORRECT : S_COMPUTE;
      S_COMPUTE: if (r_cnt == CW'(1)) w_next = S_CORRECT;
      S_CORRECT: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_dvd_lo    <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            r_sign_r <= dividend[DIVIDEND_W-1];
            r_dq     <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_dvd_lo <= dividend[DIVISOR_W-1:0];
            r_rem    <= '0;
            r_dz     <= w_dz_in;
            r_cnt    <= w_dz_in ? '0 : CW'(DIVIDEND_W);
            ready    <= 1'b0;
          end
        end
        S_COMPUTE: begin
          r_rem <= w_ge ? w_diff[PW-1:0] : w_sh;
          r_dq  <= {r_dq[DIVIDEND_W-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_CORRECT: begin
          if (r_dz) begin
            quotient    <= '1;
            remainder   <= r_dvd_lo;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= r_sign_q ? -w_qlo : w_qlo;
            remainder   <= r_sign_r ? -w_rm : w_rm;
            overflow    <= w_ovf;
            div_by_zero <= 1'b0;
          end
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix2_divider.sv
// Directed-vector bench for booth_radix2_divider with hand-computed results.
module tb_booth_radix2_divider;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient, remainder;
  logic        ready, busy, overflow, div_by_zero;

  int vectors = 0;
  int miscompares = 0;
  int n;

  booth_radix2_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .ready(ready), .busy(busy),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
  endtask

  task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic eov,
                        input logic edz, input int ecyc);
    launch(a, b);
    check({tag, ".ready_clr"}, 32'(ready), 32'd0);
    wait_ready();
    check({tag, ".cycles"}, 32'(n), 32'(ecyc));
    check({tag, ".q"}, 32'(quotient), 32'(eq));
    check({tag, ".r"}, 32'(remainder), 32'(er));
    check({tag, ".ovf"}, 32'(overflow), 32'(eov));
    check({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.outs", {16'(quotient), 8'(remainder), 6'd0, overflow, div_by_zero}, 32'd0);
    @(negedge clk); reset = 1'b0;

    do_div("1000/10",     16'd1000,   8'd10,   8'h64, 8'h00, 1'b0, 1'b0, 17);
    do_div("-701/7",      -16'sd701,  8'd7,    8'h9C, 8'hFF, 1'b0, 1'b0, 17);
    do_div("1000/-7",     16'd1000,   -8'sd7,  8'h72, 8'h06, 1'b1, 1'b0, 17);
    do_div("16384/-128",  16'd16384,  8'h80,   8'h80, 8'h00, 1'b0, 1'b0, 17);
    do_div("-16384/-128", -16'sd16384, 8'h80,  8'h80, 8'h00, 1'b1, 1'b0, 17);
    do_div("-32768/-1",   16'h8000,   8'hFF,   8'h00, 8'h00, 1'b1, 1'b0, 17);
    do_div("-7/2",        -16'sd7,    8'd2,    8'hFD, 8'hFF, 1'b0, 1'b0, 17);
    do_div("7/-2",        16'd7,      -8'sd2,  8'hFD, 8'h01, 1'b0, 1'b0, 17);
    do_div("127/1",       16'd127,    8'd1,    8'h7F, 8'h00, 1'b0, 1'b0, 17);

    // Results and ready hold while idle with start low.
    @(negedge clk); dividend = 16'd9; divisor = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("hold.ready", 32'(ready), 32'd1);
    check("hold.q", 32'(quotient), 32'h7F);

    // Start while busy is ignored.
    launch(16'd1000, 8'd10);
    repeat (4) begin @(posedge clk); #1; n++; end
    @(negedge clk); dividend = 16'd300; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1; n++;
    start = 1'b0;
    check("busystart.busy", 32'(busy), 32'd1);
    wait_ready();
    check("busystart.cycles", 32'(n), 32'd17);
    check("busystart.q", 32'(quotient), 32'h64);
    check("busystart.r", 32'(remainder), 32'h00);

    do_div("500/0", 16'd500, 8'd0, 8'hFF, 8'hF4, 1'b0, 1'b1, 1);

    // Reset in the middle of an operation.
    launch(16'd1000, 8'd10);
    repeat (7) begin @(posedge clk); #1; n++; end
    check("midrst.busy_before", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.ready", 32'(ready), 32'd0);
    check("midrst.outs", {16'(quotient), 8'(remainder), 6'd0, overflow, div_by_zero}, 32'd0);
    @(negedge clk); reset = 1'b0;
    do_div("after_rst", 16'd1000, 8'd10, 8'h64, 8'h00, 1'b0, 1'b0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
